// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 PRGA/decrypt stage: FSM state encoding,
// text-range constants, default message length and S-RAM geometry.
package rc4_pkg;

  localparam int unsigned MSG_LEN_DEF = 32;
  localparam int unsigned SRAM_DEPTH  = 256;

  localparam logic [7:0] ASCII_LO = 8'h61;
  localparam logic [7:0] ASCII_HI = 8'h7A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_RD_I,
    ST_WT_I,
    ST_RD_J,
    ST_WT_J,
    ST_WR_I,
    ST_WR_J,
    ST_RD_F,
    ST_WT_F,
    ST_OUT,
    ST_DONE
  } rc4_state_e;

  // Printable lowercase letter or space.
  function automatic logic is_text(input logic [7:0] b);
    return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SP);
  endfunction

  // Address width for a message buffer; a 1-byte buffer still needs 1 bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// Memory-side bus of the RC4 decrypt stage.
//   s_addr/s_data/s_wren/s_q     : S-box RAM (256x8)
//   rom_addr/rom_q               : encrypted-message ROM
//   d_addr/d_data/d_wren         : decrypted-message RAM
// master = decrypt engine, slave = memories. All memories register the
// address and return q one cycle later.
interface rc4_prga_decrypt_if #(
  parameter int unsigned AW = 5
);
  logic [7:0]    s_addr;
  logic [7:0]    s_data;
  logic          s_wren;
  logic [7:0]    s_q;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_q;
  logic [AW-1:0] d_addr;
  logic [7:0]    d_data;
  logic          d_wren;

  modport master (
    output s_addr, s_data, s_wren, rom_addr, d_addr, d_data, d_wren,
    input  s_q, rom_q
  );

  modport slave (
    input  s_addr, s_data, s_wren, rom_addr, d_addr, d_data, d_wren,
    output s_q, rom_q
  );
endinterface

// File: rtl/rc4_text_check.sv
// Running "all bytes are text" flag.
//   clr       : set the flag (new candidate key)
//   en        : fold data_in into the flag this cycle
//   data_in   : byte under test
//   ok        : registered accumulated flag
//   byte_ok_c : combinational validity of data_in alone
module rc4_text_check
  import rc4_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data_in,
  output logic       ok,
  output logic       byte_ok_c
);

  assign byte_ok_c = is_text(data_in);

  // Sticky clear: one bad byte rejects the whole candidate.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ok <= 1'b0;
    end else if (clr) begin
      ok <= 1'b1;
    end else if (en && !byte_ok_c) begin
      ok <= 1'b0;
    end
  end

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator and decryptor. Runs the PRGA over MSG_LEN bytes
// on the key-scheduled S-box, permuting S in place, writes E^keystream to
// the decrypted RAM and reports whether every written byte is text.
//   CLOCK_50, reset_n : clock, async active-low reset
//   start             : begin a run (sampled only when idle)
//   busy              : run in progress (INIT through DONE)
//   done              : one-cycle completion pulse
//   key_ok            : all written bytes were text; valid while done
//   bus               : S-RAM, encrypted ROM and decrypted RAM ports
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN  = MSG_LEN_DEF,
  parameter bit          CHECK_EN = 1'b1
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                key_ok,
  rc4_prga_decrypt_if.master  bus
);

  localparam int unsigned AW   = addr_w(MSG_LEN);
  localparam int unsigned S_AW = $clog2(SRAM_DEPTH);
  localparam logic [7:0]  LAST = 8'(MSG_LEN - 1);

  rc4_state_e      state;
  logic [7:0]      i, j, k, si, sj;
  logic [S_AW-1:0] s_addr_r;
  logic [7:0]      s_data_r;
  logic            s_wren_r;
  logic [AW-1:0]   rom_addr_r;
  logic [AW-1:0]   d_addr_r;
  logic [7:0]      d_data_r;
  logic            d_wren_r;
  logic            text_byte_ok_c;
  logic            abort_c;

  assign bus.s_addr   = s_addr_r;
  assign bus.s_data   = s_data_r;
  assign bus.s_wren   = s_wren_r;
  assign bus.rom_addr = rom_addr_r;
  assign bus.d_addr   = d_addr_r;
  assign bus.d_data   = d_data_r;
  assign bus.d_wren   = d_wren_r;

  // Validity of the byte currently being written (d_data is live in OUT).
  rc4_text_check u_text_check (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .clr       ((state == ST_IDLE) && start),
    .en        (state == ST_OUT),
    .data_in   (d_data_r),
    .ok        (key_ok),
    .byte_ok_c (text_byte_ok_c)
  );

  assign abort_c = CHECK_EN && !text_byte_ok_c;

  // Addresses are registered on entry to each RD_*/WR_* state so the memory
  // sees them for the whole state; q arrives in the matching WT_* state.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      si         <= '0;
      sj         <= '0;
      s_addr_r   <= '0;
      s_data_r   <= '0;
      s_wren_r   <= 1'b0;
      rom_addr_r <= '0;
      d_addr_r   <= '0;
      d_data_r   <= '0;
      d_wren_r   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      s_wren_r <= 1'b0;
      d_wren_r <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= ST_INIT;
          end
        end
        ST_INIT: begin
          // i cleared and pre-incremented in one step for the first read.
          i        <= 8'd1;
          j        <= 8'd0;
          k        <= 8'd0;
          s_addr_r <= 8'd1;
          state    <= ST_RD_I;
        end
        ST_RD_I: state <= ST_WT_I;
        ST_WT_I: begin
          si       <= bus.s_q;
          j        <= j + bus.s_q;
          s_addr_r <= j + bus.s_q;
          state    <= ST_RD_J;
        end
        ST_RD_J: state <= ST_WT_J;
        ST_WT_J: begin
          sj       <= bus.s_q;
          s_addr_r <= i;
          s_data_r <= bus.s_q;
          s_wren_r <= 1'b1;
          state    <= ST_WR_I;
        end
        ST_WR_I: begin
          // When i == j this second write lands last, leaving S[i] = si.
          s_addr_r <= j;
          s_data_r <= si;
          s_wren_r <= 1'b1;
          state    <= ST_WR_J;
        end
        ST_WR_J: begin
          s_addr_r   <= si + sj;
          rom_addr_r <= AW'(k);
          state      <= ST_RD_F;
        end
        ST_RD_F: state <= ST_WT_F;
        ST_WT_F: begin
          d_addr_r <= AW'(k);
          d_data_r <= bus.s_q ^ bus.rom_q;
          d_wren_r <= 1'b1;
          state    <= ST_OUT;
        end
        ST_OUT: begin
          if ((k == LAST) || abort_c) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            k        <= k + 8'd1;
            i        <= i + 8'd1;
            s_addr_r <= i + 8'd1;
            state    <= ST_RD_I;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
